// File: rtl/nukv_privacy_pkg.sv
// Shared definitions for the privacy pipeline output stage: word geometry,
// status word layout, length-to-word conversion and framer states.
package nukv_privacy_pkg;

  localparam int PKG_MEMORY_WIDTH = 512;
  localparam int WORD_BYTES       = PKG_MEMORY_WIDTH / 8;
  localparam int LEN_W            = 16;

  localparam int ST_LONG  = 31;
  localparam int ST_SHORT = 30;
  localparam int ST_CNT_W = 16;

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  // A zero-length value still occupies one word on the bus.
  function automatic logic [ST_CNT_W-1:0] len_to_words(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] words;
    words = ({1'b0, len} + (LEN_W+1)'(WORD_BYTES - 1)) / (LEN_W+1)'(WORD_BYTES);
    if (words == '0) words = (LEN_W+1)'(1);
    return ST_CNT_W'(words);
  endfunction

endpackage

// File: rtl/nukv_privacy_output_framer.sv
// Re-frames privacy pipeline output values against their length field,
// emits one status word per frame and keeps frame/error statistics.
module nukv_privacy_output_framer
  import nukv_privacy_pkg::*;
#(
  parameter int MEMORY_WIDTH        = 512,
  parameter int VALUE_SIZE_BYTES_NO = 2,
  parameter int STAT_WIDTH          = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MEMORY_WIDTH-1:0] input_data,
  input  logic                    input_valid,
  input  logic                    input_last,
  output logic                    input_ready,
  output logic [MEMORY_WIDTH-1:0] output_data,
  output logic                    output_valid,
  output logic                    output_last,
  input  logic                    output_ready,
  output logic [31:0]             status_data,
  output logic                    status_valid,
  input  logic                    status_ready,
  output logic [STAT_WIDTH-1:0]   stat_frames,
  output logic [STAT_WIDTH-1:0]   stat_errors
);

  state_t                         r_state;
  logic [ST_CNT_W-1:0]            r_exp;
  logic [ST_CNT_W-1:0]            r_rcv;
  logic                           r_status_valid;
  logic [31:0]                    r_status_data;
  logic [STAT_WIDTH-1:0]          r_stat_frames;
  logic [STAT_WIDTH-1:0]          r_stat_errors;

  logic [8*VALUE_SIZE_BYTES_NO-1:0] w_len;
  logic [ST_CNT_W-1:0]            w_exp_new;
  logic [ST_CNT_W-1:0]            w_rcv_inc;
  logic [ST_CNT_W-1:0]            w_cnt;
  logic                           w_slot_free;
  logic                           w_ready;
  logic                           w_ovalid;
  logic                           w_olast;
  logic                           w_acc;
  logic                           w_finish;
  logic                           w_short;
  logic                           w_long;
  state_t                         w_next_state;

  assign w_len       = input_data[8*VALUE_SIZE_BYTES_NO-1:0];
  assign w_exp_new   = len_to_words(w_len);
  assign w_slot_free = !r_status_valid || status_ready;
  assign w_rcv_inc   = (r_rcv == '1) ? r_rcv : r_rcv + 1'b1;
  assign w_acc       = input_valid && w_ready;

  always_comb begin
    w_ready      = 1'b0;
    w_ovalid     = 1'b0;
    w_olast      = 1'b0;
    w_finish     = 1'b0;
    w_short      = 1'b0;
    w_long       = 1'b0;
    w_cnt        = w_rcv_inc;
    w_next_state = r_state;
    case (r_state)
      HEAD: begin
        // The first word is held off while an unconsumed status word is pending.
        w_ready  = output_ready && w_slot_free;
        w_ovalid = input_valid && w_slot_free;
        w_olast  = input_last || (w_exp_new == ST_CNT_W'(1));
        w_cnt    = ST_CNT_W'(1);
        if (input_valid && w_ready) begin
          if (input_last) begin
            w_finish = 1'b1;
            w_short  = (w_exp_new != ST_CNT_W'(1));
          end else if (w_exp_new == ST_CNT_W'(1)) begin
            w_next_state = DROP;
          end else begin
            w_next_state = BODY;
          end
        end
      end
      BODY: begin
        w_ready  = output_ready;
        w_ovalid = input_valid;
        w_olast  = input_last || (w_rcv_inc == r_exp);
        if (input_valid && w_ready) begin
          if (input_last) begin
            w_finish     = 1'b1;
            w_short      = (w_rcv_inc < r_exp);
            w_next_state = HEAD;
          end else if (w_rcv_inc == r_exp) begin
            w_next_state = DROP;
          end
        end
      end
      DROP: begin
        w_ready = 1'b1;
        if (input_valid && input_last) begin
          w_finish     = 1'b1;
          w_long       = 1'b1;
          w_next_state = HEAD;
        end
      end
      default: w_next_state = HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= HEAD;
      r_exp          <= '0;
      r_rcv          <= '0;
      r_status_valid <= 1'b0;
      r_status_data  <= '0;
      r_stat_frames  <= '0;
      r_stat_errors  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_acc) begin
        if (r_state == HEAD) begin
          r_exp <= w_exp_new;
          r_rcv <= ST_CNT_W'(1);
        end else begin
          r_rcv <= w_rcv_inc;
        end
      end
      // A finish in the same cycle as a status handshake replaces the old word.
      if (w_finish) begin
        r_status_data  <= {w_long, w_short, 14'b0, w_cnt};
        r_status_valid <= 1'b1;
        r_stat_frames  <= r_stat_frames + 1'b1;
        if (w_short || w_long) r_stat_errors <= r_stat_errors + 1'b1;
      end else if (status_ready) begin
        r_status_valid <= 1'b0;
      end
    end
  end

  assign input_ready  = w_ready;
  assign output_data  = input_data;
  assign output_valid = w_ovalid;
  assign output_last  = w_olast && w_ovalid;
  assign status_data  = r_status_data;
  assign status_valid = r_status_valid;
  assign stat_frames  = r_stat_frames;
  assign stat_errors  = r_stat_errors;

endmodule

// File: tb/tb_nukv_privacy_output_framer.sv
// Bench for the privacy output framer: directed frame table, status stall,
// mid-frame reset and randomized traffic against a frame-level model.
module tb_nukv_privacy_output_framer;

  localparam int MW = 512;
  localparam int WB = MW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [MW-1:0] input_data;
  logic          input_valid;
  logic          input_last;
  logic          input_ready;
  logic [MW-1:0] output_data;
  logic          output_valid;
  logic          output_last;
  logic          output_ready;
  logic [31:0]   status_data;
  logic          status_valid;
  logic          status_ready;
  logic [31:0]   stat_frames;
  logic [31:0]   stat_errors;

  always #5 clk = ~clk;

  nukv_privacy_output_framer #(
    .MEMORY_WIDTH(MW), .VALUE_SIZE_BYTES_NO(2), .STAT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .input_data(input_data), .input_valid(input_valid), .input_last(input_last),
    .input_ready(input_ready),
    .output_data(output_data), .output_valid(output_valid), .output_last(output_last),
    .output_ready(output_ready),
    .status_data(status_data), .status_valid(status_valid), .status_ready(status_ready),
    .stat_frames(stat_frames), .stat_errors(stat_errors)
  );

  typedef struct {
    logic [MW-1:0] d;
    logic          l;
  } word_t;

  typedef struct {
    int          len;
    int          n;
    int          n_out;
    logic [31:0] st;
    int          frames;
    int          errors;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          rnd_mode = 1'b0;
  int          m_frames, m_errors;
  word_t       got_out[$];
  word_t       exp_out[$];
  logic [31:0] got_st[$];
  logic [31:0] exp_st[$];
  word_t       mon_w;
  vec_t        tbl[6];

  // Observe handshakes just before the rising edge.
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      if (output_valid && output_ready) begin
        mon_w.d = output_data;
        mon_w.l = output_last;
        got_out.push_back(mon_w);
      end
      if (status_valid && status_ready) got_st.push_back(status_data);
    end
  end

  task automatic chk(input string nm, input logic [MW-1:0] got, input logic [MW-1:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rnd_mode) begin
      output_ready = ($urandom % 4) != 0;
      status_ready = ($urandom % 2) != 0;
    end
  endtask

  function automatic logic [MW-1:0] rnd_word();
    logic [MW-1:0] w;
    for (int i = 0; i < MW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic send_word(input logic [MW-1:0] d, input logic l);
    int guard = 0;
    bit done = 1'b0;
    if (rnd_mode && ($urandom % 4) == 0) begin
      tick();
      input_valid = 1'b0;
    end
    tick();
    input_data  = d;
    input_last  = l;
    input_valid = 1'b1;
    while (!done) begin
      #4;
      if (input_ready) begin
        done = 1'b1;
      end else begin
        guard++;
        if (guard > 300) begin
          n_tests++;
          n_fail++;
          $display("FAIL word_accept_timeout: input_ready stuck at 0 after %0d cycles", guard);
          $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
          $fatal(1, "timeout");
        end
        tick();
      end
    end
  endtask

  // Frame-level model: forwarded words are the first min(n, exp), last on the final one.
  task automatic send_frame(input int len, input int n);
    int e, m;
    logic [MW-1:0] w;
    word_t ew;
    e = (len + WB - 1) / WB;
    if (e == 0) e = 1;
    m = (n < e) ? n : e;
    for (int i = 0; i < n; i++) begin
      w = rnd_word();
      if (i == 0) w[15:0] = 16'(len);
      if (i < m) begin
        ew.d = w;
        ew.l = (i == m - 1);
        exp_out.push_back(ew);
      end
      send_word(w, i == n - 1);
    end
    exp_st.push_back({(n > e), (n < e), 14'b0, 16'(n)});
    m_frames++;
    if (n != e) m_errors++;
    tick();
    input_valid = 1'b0;
    input_last  = 1'b0;
  endtask

  initial begin
    logic [MW-1:0] wb;
    rst = 1'b1;
    input_data = '0; input_valid = 1'b0; input_last = 1'b0;
    output_ready = 1'b1; status_ready = 1'b1;
    m_frames = 0; m_errors = 0;

    tbl[0] = '{len: 100, n: 2, n_out: 2, st: 32'h0000_0002, frames: 1, errors: 0};
    tbl[1] = '{len: 64,  n: 1, n_out: 1, st: 32'h0000_0001, frames: 2, errors: 0};
    tbl[2] = '{len: 200, n: 2, n_out: 2, st: 32'h4000_0002, frames: 3, errors: 1};
    tbl[3] = '{len: 64,  n: 3, n_out: 1, st: 32'h8000_0003, frames: 4, errors: 2};
    tbl[4] = '{len: 0,   n: 1, n_out: 1, st: 32'h0000_0001, frames: 5, errors: 2};
    tbl[5] = '{len: 129, n: 3, n_out: 3, st: 32'h0000_0003, frames: 6, errors: 2};

    repeat (3) tick();
    rst = 1'b0;
    #4;
    chk("rst_status_valid", MW'(status_valid), MW'(0));
    chk("rst_status_data", MW'(status_data), MW'(0));
    chk("rst_stat_frames", MW'(stat_frames), MW'(0));
    chk("rst_stat_errors", MW'(stat_errors), MW'(0));
    chk("rst_input_ready", MW'(input_ready), MW'(1));
    chk("rst_output_valid", MW'(output_valid), MW'(0));

    foreach (tbl[t]) begin
      got_out.delete(); got_st.delete(); exp_out.delete();
      send_frame(tbl[t].len, tbl[t].n);
      repeat (3) tick();
      chk($sformatf("tbl%0d_out_count", t), MW'(got_out.size()), MW'(tbl[t].n_out));
      for (int k = 0; k < got_out.size() && k < exp_out.size(); k++) begin
        chk($sformatf("tbl%0d_data%0d", t, k), got_out[k].d, exp_out[k].d);
        chk($sformatf("tbl%0d_last%0d", t, k), MW'(got_out[k].l), MW'(k == tbl[t].n_out - 1));
      end
      chk($sformatf("tbl%0d_status_count", t), MW'(got_st.size()), MW'(1));
      if (got_st.size() > 0) chk($sformatf("tbl%0d_status", t), MW'(got_st[0]), MW'(tbl[t].st));
      chk($sformatf("tbl%0d_frames", t), MW'(stat_frames), MW'(tbl[t].frames));
      chk($sformatf("tbl%0d_errors", t), MW'(stat_errors), MW'(tbl[t].errors));
    end

    // Status slot occupied: the next frame's head word must wait for status_ready.
    got_st.delete();
    tick();
    status_ready = 1'b0;
    send_frame(64, 1);
    wb = rnd_word();
    wb[15:0] = 16'd64;
    input_data = wb; input_valid = 1'b1; input_last = 1'b1;
    #4;
    chk("stall_ready0", MW'(input_ready), MW'(0));
    chk("stall_ovalid0", MW'(output_valid), MW'(0));
    repeat (2) begin
      tick();
      #4;
      chk("stall_ready_hold", MW'(input_ready), MW'(0));
    end
    tick();
    status_ready = 1'b1;
    #4;
    chk("stall_release_ready", MW'(input_ready), MW'(1));
    chk("stall_release_svalid", MW'(status_valid), MW'(1));
    tick();
    status_ready = 1'b0; input_valid = 1'b0; input_last = 1'b0;
    #4;
    chk("stall_new_svalid", MW'(status_valid), MW'(1));
    chk("stall_new_sdata", MW'(status_data), MW'(1));
    chk("stall_consumed1", MW'(got_st.size()), MW'(1));
    tick();
    status_ready = 1'b1;
    repeat (2) tick();
    chk("stall_consumed2", MW'(got_st.size()), MW'(2));
    chk("stall_frames", MW'(stat_frames), MW'(8));

    // Reset in the middle of a multi-word frame.
    got_out.delete(); got_st.delete(); exp_out.delete();
    wb = rnd_word();
    wb[15:0] = 16'd300;
    send_word(wb, 1'b0);
    send_word(rnd_word(), 1'b0);
    tick();
    input_valid = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #4;
    chk("midrst_svalid", MW'(status_valid), MW'(0));
    chk("midrst_sdata", MW'(status_data), MW'(0));
    chk("midrst_frames", MW'(stat_frames), MW'(0));
    chk("midrst_errors", MW'(stat_errors), MW'(0));
    chk("midrst_out_count", MW'(got_out.size()), MW'(2));
    if (got_out.size() == 2) chk("midrst_no_last", MW'(got_out[0].l | got_out[1].l), MW'(0));
    got_out.delete(); got_st.delete(); exp_out.delete();
    send_frame(100, 2);
    repeat (3) tick();
    chk("postrst_status_count", MW'(got_st.size()), MW'(1));
    if (got_st.size() > 0) chk("postrst_status", MW'(got_st[0]), MW'(2));
    chk("postrst_frames", MW'(stat_frames), MW'(1));
    chk("postrst_out_count", MW'(got_out.size()), MW'(2));
    if (got_out.size() == 2) chk("postrst_last", MW'(got_out[1].l), MW'(1));

    // Randomized traffic with backpressure on both outputs.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    got_out.delete(); got_st.delete(); exp_out.delete(); exp_st.delete();
    m_frames = 0; m_errors = 0;
    rnd_mode = 1'b1;
    for (int f = 0; f < 40; f++) send_frame($urandom_range(0, 400), $urandom_range(1, 8));
    rnd_mode = 1'b0;
    tick();
    output_ready = 1'b1; status_ready = 1'b1;
    repeat (5) tick();
    chk("rnd_out_count", MW'(got_out.size()), MW'(exp_out.size()));
    for (int k = 0; k < got_out.size() && k < exp_out.size(); k++) begin
      chk($sformatf("rnd_data%0d", k), got_out[k].d, exp_out[k].d);
      chk($sformatf("rnd_last%0d", k), MW'(got_out[k].l), MW'(exp_out[k].l));
    end
    chk("rnd_status_count", MW'(got_st.size()), MW'(exp_st.size()));
    for (int k = 0; k < got_st.size() && k < exp_st.size(); k++)
      chk($sformatf("rnd_status%0d", k), MW'(got_st[k]), MW'(exp_st[k]));
    chk("rnd_frames", MW'(stat_frames), MW'(m_frames));
    chk("rnd_errors", MW'(stat_errors), MW'(m_errors));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
